// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline sequencing controller.
// The state encoding and register-field width are used by the controller and the hazard compare.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        MEM_WAIT = 2'd2
    } state_t;

    localparam logic [4:0] XZR   = 5'd31;
    localparam int         REG_W = 5;

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use hazard compare between the load in EX and the operands of the instruction in ID.
// X31/XZR is hard-wired zero, so a load targeting it never creates a dependency.
module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [REG_W-1:0] id_rn,
    input  logic [REG_W-1:0] id_rm,
    input  logic             id_uses_rm,
    input  logic             ex_memtoreg,
    input  logic [REG_W-1:0] ex_rd,
    output logic             load_use
);

    logic rn_match;
    logic rm_match;

    assign rn_match = (ex_rd == id_rn);
    assign rm_match = id_uses_rm & (ex_rd == id_rm);
    assign load_use = ex_memtoreg & (ex_rd != XZR) & (rn_match | rm_match);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: load-use stalls, branch flushes and data-memory wait with timeout.
// Defining HAZ_PERF_CNT_EN adds saturating stall/flush/memory-wait performance counters.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] id_rn,
    input  logic [REG_W-1:0] id_rm,
    input  logic             id_uses_rm,
    input  logic             ex_memtoreg,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             br_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             exmem_en,
    output logic             memwb_bubble,
    output logic             mem_err,
    output logic             busy
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [31:0]      stall_cycles,
    output logic [31:0]      flush_count,
    output logic [31:0]      memwait_cycles
`endif
);

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] wait_cnt_reg, wait_cnt_next;
    logic             mem_err_reg, mem_err_next;
    logic             load_use;
    logic             mem_wait;

    hazard_detect u_hazard_detect (
        .id_rn       (id_rn),
        .id_rm       (id_rm),
        .id_uses_rm  (id_uses_rm),
        .ex_memtoreg (ex_memtoreg),
        .ex_rd       (ex_rd),
        .load_use    (load_use)
    );

    assign mem_wait = mem_req & ~mem_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= RUN;
            wait_cnt_reg <= '0;
            mem_err_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
            mem_err_reg  <= mem_err_next;
        end
    end

    always_comb begin
        pc_en         = 1'b1;
        ifid_en       = 1'b1;
        ifid_flush    = 1'b0;
        idex_bubble   = 1'b0;
        exmem_en      = 1'b1;
        memwb_bubble  = 1'b0;
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        mem_err_next  = mem_err_reg;

        case (state_reg)
            // LU_STALL re-evaluates hazards exactly like RUN; EX now holds the bubble.
            RUN, LU_STALL: begin
                if (mem_wait) begin
                    pc_en         = 1'b0;
                    ifid_en       = 1'b0;
                    exmem_en      = 1'b0;
                    memwb_bubble  = 1'b1;
                    state_next    = MEM_WAIT;
                    wait_cnt_next = CNT_W'(1);
                end else if (load_use) begin
                    pc_en       = 1'b0;
                    ifid_en     = 1'b0;
                    idex_bubble = 1'b1;
                    state_next  = LU_STALL;
                end else begin
                    ifid_flush = br_taken;
                    state_next = RUN;
                end
            end
            MEM_WAIT: begin
                pc_en        = 1'b0;
                ifid_en      = 1'b0;
                exmem_en     = 1'b0;
                memwb_bubble = 1'b1;
                if (mem_ready) begin
                    pc_en         = 1'b1;
                    ifid_en       = 1'b1;
                    exmem_en      = 1'b1;
                    memwb_bubble  = 1'b0;
                    state_next    = RUN;
                    wait_cnt_next = '0;
                end else if (wait_cnt_reg == CNT_W'(MEM_TIMEOUT)) begin
                    // Access abandoned: the MEM/WB slot stays a bubble and the error latches.
                    mem_err_next  = 1'b1;
                    state_next    = RUN;
                    wait_cnt_next = '0;
                end else if (wait_cnt_reg != '1) begin
                    wait_cnt_next = wait_cnt_reg + CNT_W'(1);
                end
            end
            default: begin
                state_next    = RUN;
                wait_cnt_next = '0;
            end
        endcase
    end

    assign mem_err = mem_err_reg;
    assign busy    = (state_reg != RUN);

`ifdef HAZ_PERF_CNT_EN
    logic [2:0] perf_inc;

    assign perf_inc = {(state_reg == MEM_WAIT), ifid_flush, ~pc_en};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_perf
            logic [31:0] cnt_reg;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    cnt_reg <= '0;
                end else if (perf_inc[gi] && (cnt_reg != 32'hFFFF_FFFF)) begin
                    cnt_reg <= cnt_reg + 32'd1;
                end
            end
        end
    endgenerate

    assign stall_cycles   = g_perf[0].cnt_reg;
    assign flush_count    = g_perf[1].cnt_reg;
    assign memwait_cycles = g_perf[2].cnt_reg;
`endif

endmodule
